// File: rtl/sdram_arbiter.sv
// Round-robin arbiter that shares one SDRAM controller port between NUM_REQ masters.
// A grant is held until the controller finishes, the owner drops its request, or the watchdog expires.
module sdram_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  output logic [DATA_W-1:0]         req_readdata,
  output logic [NUM_REQ-1:0]        req_finished,
  output logic                      sdram_read,
  output logic                      sdram_write,
  output logic [ADDR_W-1:0]         sdram_addr,
  output logic [DATA_W-1:0]         sdram_writedata,
  input  logic [DATA_W-1:0]         sdram_readdata,
  input  logic                      sdram_finished,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WDOG_W = $clog2(TIMEOUT + 1) + 1;
  localparam int unsigned N = NUM_REQ;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [IDX_W-1:0]   g_idx;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic               pick_valid;
  logic [WDOG_W-1:0]  wdog;
  logic [NUM_REQ-1:0] req_any;
  logic               in_grant;
  logic               sel_read;
  logic               sel_write;
  logic               sel_any;
  logic               wdog_expired;
  logic               done;

  assign req_any      = req_read | req_write;
  assign in_grant     = (state == GRANT);
  assign sel_read     = req_read[g_idx];
  assign sel_write    = req_write[g_idx];
  assign sel_any      = sel_read | sel_write;
  assign wdog_expired = (wdog == WDOG_W'(TIMEOUT - 1));
  assign done         = in_grant & sdram_finished;

  // Search starts one past the previous owner so it has the lowest priority next round.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IDX_W'((32'(last_grant) + i) % N);
      if (!pick_valid && req_any[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Controller side is gated by the state register so an async reset drops it at once.
  always_comb begin
    sdram_read      = in_grant & sel_read & ~sel_write;
    sdram_write     = in_grant & sel_write;
    sdram_addr      = in_grant ? req_addr[g_idx*ADDR_W +: ADDR_W] : '0;
    sdram_writedata = in_grant ? req_writedata[g_idx*DATA_W +: DATA_W] : '0;
    req_finished    = done ? grant : '0;
    req_readdata    = done ? sdram_readdata : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      wdog        <= '0;
      g_idx       <= '0;
      last_grant  <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          wdog <= '0;
          if (pick_valid) begin
            state <= GRANT;
            g_idx <= pick_idx;
            grant <= NUM_REQ'(1) << pick_idx;
            busy  <= 1'b1;
          end
        end
        GRANT: begin
          if (sdram_finished || !sel_any || wdog_expired) begin
            state      <= IDLE;
            grant      <= '0;
            busy       <= 1'b0;
            wdog       <= '0;
            last_grant <= g_idx;
            if (!sdram_finished && sel_any) err_timeout <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus a randomized run checked by a queue scoreboard.
module tb_sdram_arbiter;

  localparam int NR = 3;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int TO = 15;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic [NR-1:0]     req_read, req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_writedata;
  logic [DW-1:0]     req_readdata;
  logic [NR-1:0]     req_finished;
  logic              sdram_read, sdram_write;
  logic [AW-1:0]     sdram_addr;
  logic [DW-1:0]     sdram_writedata;
  logic [DW-1:0]     sdram_readdata;
  logic              sdram_finished;
  logic [NR-1:0]     grant;
  logic              busy, err_timeout;

  sdram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_writedata(req_writedata),
    .req_readdata(req_readdata), .req_finished(req_finished),
    .sdram_read(sdram_read), .sdram_write(sdram_write),
    .sdram_addr(sdram_addr), .sdram_writedata(sdram_writedata),
    .sdram_readdata(sdram_readdata), .sdram_finished(sdram_finished),
    .grant(grant), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_read[k]  = rd;
    req_write[k] = wr;
    req_addr[k*AW +: AW]      = a;
    req_writedata[k*DW +: DW] = d;
  endtask

  task automatic do_reset();
    i_rst_n        = 1'b0;
    req_read       = '0;
    req_write      = '0;
    sdram_finished = 1'b0;
    repeat (2) tick();
    i_rst_n = 1'b1;
  endtask

  // Reference arbitration: first pending requester after the previous owner, modulo NR.
  function automatic int rr_pick(input int last_k, input logic [NR-1:0] pend);
    for (int i = 1; i <= NR; i++)
      if (pend[(last_k + i) % NR]) return (last_k + i) % NR;
    return -1;
  endfunction

  typedef struct {
    int            idx;
    logic [AW-1:0] addr;
    logic          wr;
    logic          rd;
    logic [DW-1:0] wdata;
  } acc_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } fin_t;

  acc_t        acc_q[$];
  fin_t        fin_q[$];
  acc_t        m_acc;
  fin_t        m_fin;
  bit          mon_en = 1'b0;
  logic [NR-1:0] prev_grant = '0;

  always @(negedge i_clk) begin
    if (mon_en) begin
      if (grant !== prev_grant && grant !== '0) begin
        if (acc_q.size() == 0) check("unexpected_grant", 64'(grant), 64'(0));
        else begin
          m_acc = acc_q.pop_front();
          check("sb_grant", 64'(grant), 64'(1) << m_acc.idx);
          check("sb_addr", 64'(sdram_addr), 64'(m_acc.addr));
          check("sb_write", 64'(sdram_write), 64'(m_acc.wr));
          check("sb_read", 64'(sdram_read), 64'(m_acc.rd));
          check("sb_wdata", 64'(sdram_writedata), 64'(m_acc.wdata));
        end
      end
      if (req_finished !== '0) begin
        if (fin_q.size() == 0) check("unexpected_finished", 64'(req_finished), 64'(0));
        else begin
          m_fin = fin_q.pop_front();
          check("sb_finished", 64'(req_finished), 64'(1) << m_fin.idx);
          check("sb_readdata", 64'(req_readdata), 64'(m_fin.data));
        end
      end
    end
    prev_grant = grant;
  end

  logic [NR-1:0] pv;
  logic [AW-1:0] t_addr [NR];
  logic [DW-1:0] t_data [NR];
  logic          t_rd   [NR];
  logic          t_wr   [NR];
  int            owner, last, n_cyc, lat, clear_k, kind;
  int            rr_seq [4] = '{0, 1, 2, 0};

  initial begin
    i_rst_n = 1'b0; req_read = '0; req_write = '0; req_addr = '0; req_writedata = '0;
    sdram_readdata = '0; sdram_finished = 1'b0;
    #2;
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err", 64'(err_timeout), 64'(0));
    check("rst_sdram_rw", 64'({sdram_read, sdram_write}), 64'(0));
    check("rst_sdram_addr", 64'(sdram_addr), 64'(0));
    check("rst_fin", 64'(req_finished), 64'(0));
    check("rst_rdata", 64'(req_readdata), 64'(0));
    req_read = '1;
    tick();
    check("rst_hold_grant", 64'(grant), 64'(0));
    req_read = '0;
    i_rst_n  = 1'b1;
    tick();

    // single read on requester 0
    set_req(0, 1'b1, 1'b0, 23'h000100, '0);
    #1 check("single_pre_grant", 64'(grant), 64'(0));
    tick();
    check("single_grant", 64'(grant), 64'(3'b001));
    check("single_busy", 64'(busy), 64'(1));
    check("single_addr", 64'(sdram_addr), 64'(23'h000100));
    check("single_rw", 64'({sdram_read, sdram_write}), 64'(2'b10));
    check("single_no_fin", 64'(req_finished), 64'(0));
    tick(); tick();
    sdram_readdata = 32'hDEADBEEF; sdram_finished = 1'b1;
    #1 check("single_fin", 64'(req_finished), 64'(3'b001));
    check("single_rdata", 64'(req_readdata), 64'(32'hDEADBEEF));
    tick();
    sdram_finished = 1'b0; req_read[0] = 1'b0;
    #1 check("single_idle_grant", 64'(grant), 64'(0));
    check("single_idle_busy", 64'(busy), 64'(0));
    check("single_idle_read", 64'(sdram_read), 64'(0));

    // write wins over read on the same requester
    set_req(1, 1'b1, 1'b1, 23'h2AAAAA, 32'h12345678);
    tick();
    check("wr_grant", 64'(grant), 64'(3'b010));
    check("wr_rw", 64'({sdram_read, sdram_write}), 64'(2'b01));
    check("wr_wdata", 64'(sdram_writedata), 64'(32'h12345678));
    check("wr_addr", 64'(sdram_addr), 64'(23'h2AAAAA));
    sdram_finished = 1'b1;
    #1 check("wr_fin", 64'(req_finished), 64'(3'b010));
    tick();
    sdram_finished = 1'b0; set_req(1, 1'b0, 1'b0, '0, '0);

    // round-robin with all requesters holding reads
    do_reset();
    for (int k = 0; k < NR; k++) set_req(k, 1'b1, 1'b0, 23'(k * 16 + 5), '0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("rr_grant", 64'(grant), 64'(1) << rr_seq[i]);
      check("rr_addr", 64'(sdram_addr), 64'(rr_seq[i] * 16 + 5));
      tick();
      sdram_finished = 1'b1; sdram_readdata = 32'hA0000000 + 32'(i);
      #1 check("rr_fin", 64'(req_finished), 64'(1) << rr_seq[i]);
      check("rr_rdata", 64'(req_readdata), 64'(32'hA0000000 + 32'(i)));
      tick();
      sdram_finished = 1'b0;
      #1 check("rr_bubble", 64'(grant), 64'(0));
      tick();
    end

    // abort by requester 1, then a stray finished while idle
    check("abort_grant", 64'(grant), 64'(3'b010));
    req_read = '0;
    #1 check("abort_no_fin", 64'(req_finished), 64'(0));
    tick();
    check("abort_idle", 64'({busy, grant}), 64'(0));
    sdram_finished = 1'b1; sdram_readdata = 32'hFFFFFFFF;
    #1 check("stray_fin", 64'(req_finished), 64'(0));
    check("stray_rdata", 64'(req_readdata), 64'(0));
    tick();
    sdram_finished = 1'b0;
    check("stray_grant", 64'(grant), 64'(0));
    req_read = '1;
    tick();
    check("abort_last", 64'(grant), 64'(3'b100));

    // watchdog on requester 2 with requester 0 waiting
    req_read = 3'b101;
    for (int c = 1; c <= TO; c++) begin
      check("wdog_hold", 64'({err_timeout, grant}), 64'(4'b0100));
      tick();
    end
    check("wdog_err", 64'(err_timeout), 64'(1));
    check("wdog_release", 64'({busy, grant}), 64'(0));
    check("wdog_no_fin", 64'(req_finished), 64'(0));
    req_read[2] = 1'b0;
    tick();
    check("wdog_next", 64'(grant), 64'(3'b001));
    check("wdog_sticky", 64'(err_timeout), 64'(1));

    // async reset between edges
    #2 i_rst_n = 1'b0;
    #1 check("arst_grant", 64'(grant), 64'(0));
    check("arst_read", 64'(sdram_read), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_err", 64'(err_timeout), 64'(0));
    req_read = '1;
    tick(); tick();
    i_rst_n = 1'b1;
    tick();
    check("arst_first", 64'(grant), 64'(3'b001));

    // randomized traffic against the reference arbitration model
    do_reset();
    pv = '0; owner = -1; last = NR - 1; n_cyc = 0; lat = 0; clear_k = -1;
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (clear_k >= 0) begin
        pv[clear_k] = 1'b0;
        req_read[clear_k] = 1'b0; req_write[clear_k] = 1'b0;
        clear_k = -1;
      end
      if (cyc < 1200) begin
        for (int k = 0; k < NR; k++) begin
          if (!pv[k] && $urandom_range(0, 2) == 0) begin
            kind      = int'($urandom_range(0, 2));
            t_rd[k]   = (kind != 1);
            t_wr[k]   = (kind != 0);
            t_addr[k] = AW'($urandom);
            t_data[k] = $urandom;
            set_req(k, t_rd[k], t_wr[k], t_addr[k], t_data[k]);
            pv[k] = 1'b1;
          end
        end
      end
      sdram_finished = 1'b0;
      sdram_readdata = $urandom;
      if (owner < 0) begin
        if (pv != '0) begin
          owner = rr_pick(last, pv);
          acc_q.push_back('{owner, t_addr[owner], t_wr[owner], t_rd[owner] & ~t_wr[owner], t_data[owner]});
          n_cyc = 0;
          lat   = int'($urandom_range(1, 6));
        end
      end else begin
        n_cyc++;
        if (n_cyc == lat) begin
          sdram_finished = 1'b1;
          fin_q.push_back('{owner, sdram_readdata});
          clear_k = owner;
          last    = owner;
          owner   = -1;
        end
      end
      tick();
    end
    sdram_finished = 1'b0;
    repeat (3) tick();
    mon_en = 1'b0;
    check("sb_access_drained", 64'(acc_q.size()), 64'(0));
    check("sb_finish_drained", 64'(fin_q.size()), 64'(0));
    check("rand_end_idle", 64'({busy, grant}), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
